// File: rtl/mod_arith_ctrl.sv
// Round-robin controller sharing one modular add/sub datapath between two requesters.
// Accepts a request, presents registered operands for one cycle, then holds the result until consumed.
module mod_arith_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_sub,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_m0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [WIDTH-1:0] req_m1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] dp_opA,
  output logic [WIDTH-1:0] dp_opB,
  output logic [WIDTH-1:0] dp_opM,
  output logic             dp_sub,
  input  logic [WIDTH-1:0] dp_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             last_grant_r;
  logic             owner_r;
  logic             err_r;
  logic [1:0]       grant_oh_s;
  logic             grant_idx_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] sel_m_s;
  logic             sel_sub_s;
  logic [1:0]       resp_valid_r;
  logic [WIDTH-1:0] resp_data_r;
  logic             resp_err_r;
  logic [WIDTH-1:0] dp_a_r;
  logic [WIDTH-1:0] dp_b_r;
  logic [WIDTH-1:0] dp_m_r;
  logic             dp_sub_r;

  // Operands must be reduced residues of a non-zero modulus.
  function automatic logic range_err(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] m);
    return (a >= m) | (b >= m) | (m == {WIDTH{1'b0}});
  endfunction

  // Round-robin arbitration; ready is forced low while reset is asserted.
  always_comb begin
    grant_oh_s  = 2'b00;
    grant_idx_s = 1'b0;
    if ((state_r == IDLE) && rst_n) begin
      case (req_valid)
        2'b01: begin
          grant_oh_s  = 2'b01;
          grant_idx_s = 1'b0;
        end
        2'b10: begin
          grant_oh_s  = 2'b10;
          grant_idx_s = 1'b1;
        end
        2'b11: begin
          grant_idx_s = ~last_grant_r;
          grant_oh_s  = last_grant_r ? 2'b01 : 2'b10;
        end
        default: begin
          grant_oh_s  = 2'b00;
          grant_idx_s = 1'b0;
        end
      endcase
    end else begin
      grant_oh_s  = 2'b00;
      grant_idx_s = 1'b0;
    end
  end

  assign accept_s  = |grant_oh_s;
  assign req_ready = grant_oh_s;

  // Operand selection for the granted requester.
  always_comb begin
    sel_a_s   = req_a0;
    sel_b_s   = req_b0;
    sel_m_s   = req_m0;
    sel_sub_s = req_sub[0];
    if (grant_idx_s) begin
      sel_a_s   = req_a1;
      sel_b_s   = req_b1;
      sel_m_s   = req_m1;
      sel_sub_s = req_sub[1];
    end else begin
      sel_a_s   = req_a0;
      sel_b_s   = req_b0;
      sel_m_s   = req_m0;
      sel_sub_s = req_sub[0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (resp_ready[owner_r]) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture on acceptance; values persist until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a_r       <= {WIDTH{1'b0}};
      dp_b_r       <= {WIDTH{1'b0}};
      dp_m_r       <= {WIDTH{1'b0}};
      dp_sub_r     <= 1'b0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      err_r        <= 1'b0;
    end else if (accept_s) begin
      dp_a_r       <= sel_a_s;
      dp_b_r       <= sel_b_s;
      dp_m_r       <= sel_m_s;
      dp_sub_r     <= sel_sub_s;
      owner_r      <= grant_idx_s;
      last_grant_r <= grant_idx_s;
      err_r        <= range_err(sel_a_s, sel_b_s, sel_m_s);
    end
  end

  // Result capture in EXEC and release on the owner's response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 2'b00;
      resp_data_r  <= {WIDTH{1'b0}};
      resp_err_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_data_r  <= err_r ? {WIDTH{1'b0}} : dp_out;
      resp_err_r   <= err_r;
      resp_valid_r <= owner_r ? 2'b10 : 2'b01;
    end else if ((state_r == RESP) && resp_ready[owner_r]) begin
      resp_valid_r <= 2'b00;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign dp_opA     = dp_a_r;
  assign dp_opB     = dp_b_r;
  assign dp_opM     = dp_m_r;
  assign dp_sub     = dp_sub_r;

endmodule

// File: tb/tb_mod_arith_ctrl.sv
// Self-checking bench for mod_arith_ctrl with a behavioural modular add/sub datapath
// and a transaction-level reference model.
module tb_mod_arith_ctrl;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, req_sub, resp_valid, resp_ready;
  logic [W-1:0] req_a0, req_b0, req_m0, req_a1, req_b1, req_m1;
  logic [W-1:0] resp_data, dp_opA, dp_opB, dp_opM, dp_out;
  logic         resp_err, dp_sub;

  logic [W-1:0] op_a [2];
  logic [W-1:0] op_b [2];
  logic [W-1:0] op_m [2];
  logic         op_sub [2];
  logic         mg;
  logic         g_seen;
  int           errs = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  assign req_a0  = op_a[0];
  assign req_b0  = op_b[0];
  assign req_m0  = op_m[0];
  assign req_a1  = op_a[1];
  assign req_b1  = op_b[1];
  assign req_m1  = op_m[1];
  assign req_sub = {op_sub[1], op_sub[0]};

  // Stand-in for the modular add/sub units; garbage in gives garbage out, like the real ones.
  logic [W:0] dp_wide;
  always_comb begin
    if (dp_opM == '0) dp_wide = '0;
    else if (dp_sub) dp_wide = ({1'b0, dp_opA} + {1'b0, dp_opM} - {1'b0, dp_opB}) % {1'b0, dp_opM};
    else dp_wide = ({1'b0, dp_opA} + {1'b0, dp_opB}) % {1'b0, dp_opM};
  end
  assign dp_out = dp_wide[W-1:0];

  mod_arith_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a0(req_a0), .req_b0(req_b0), .req_m0(req_m0),
    .req_a1(req_a1), .req_b1(req_b1), .req_m1(req_m1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .dp_opA(dp_opA), .dp_opB(dp_opB), .dp_opM(dp_opM), .dp_sub(dp_sub),
    .dp_out(dp_out)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_mod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                         input logic s, output logic [W-1:0] d, output logic e);
    logic [W:0] t;
    if (m == '0 || a >= m || b >= m) begin
      e = 1'b1;
      d = '0;
    end else begin
      e = 1'b0;
      if (s) t = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
      else   t = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
      d = t[W-1:0];
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input logic s);
    op_a[r] = a; op_b[r] = b; op_m[r] = m; op_sub[r] = s;
  endtask

  task automatic rand_ops(input int r);
    logic [W-1:0] m;
    if ($urandom_range(0, 1) == 0) begin
      m = W'($urandom_range(0, 200));
      set_ops(r, W'($urandom_range(0, 32'(m) + 2)), W'($urandom_range(0, 32'(m) + 2)), m,
              1'($urandom_range(0, 1)));
    end else begin
      m = rand_w();
      if (m == '0) m = 256'd1;
      set_ops(r, ($urandom_range(0, 7) == 0) ? m : rand_w() % m, rand_w() % m, m,
              1'($urandom_range(0, 1)));
    end
  endtask

  // One full transaction from request to response handshake; returns the granted index.
  task automatic do_op(input logic [1:0] vmask, input int stall, output logic g);
    logic [1:0]   goh;
    logic [W-1:0] ed;
    logic         ee;
    g   = (vmask == 2'b11) ? ~mg : vmask[1];
    goh = g ? 2'b10 : 2'b01;
    ref_mod(op_a[g], op_b[g], op_m[g], op_sub[g], ed, ee);
    req_valid  = vmask;
    resp_ready = (stall == 0) ? 2'b11 : ~goh;
    #1;
    check_eq("grant", W'(req_ready), W'(goh));
    @(posedge clk); #1;
    mg = g;
    req_valid[g] = 1'b0;
    check_eq("dp_opA", dp_opA, op_a[g]);
    check_eq("dp_opB", dp_opB, op_b[g]);
    check_eq("dp_opM", dp_opM, op_m[g]);
    check_eq("dp_sub", W'(dp_sub), W'(op_sub[g]));
    check_eq("exec_ready", W'(req_ready), '0);
    check_eq("exec_valid", W'(resp_valid), '0);
    @(posedge clk); #1;
    check_eq("resp_valid", W'(resp_valid), W'(goh));
    check_eq("resp_data", resp_data, ed);
    check_eq("resp_err", W'(resp_err), W'(ee));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", W'(resp_valid), W'(goh));
      check_eq("hold_data", resp_data, ed);
      check_eq("hold_ready", W'(req_ready), '0);
    end
    resp_ready = 2'b11;
    @(posedge clk); #1;
    check_eq("resp_done", W'(resp_valid), '0);
  endtask

  initial begin
    logic g;
    rst_n = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    mg = 1'b1;
    for (int r = 0; r < 2; r++) set_ops(r, '0, '0, '0, 1'b0);
    #12;
    check_eq("rst_req_ready", W'(req_ready), '0);
    check_eq("rst_resp_valid", W'(resp_valid), '0);
    check_eq("rst_resp_data", resp_data, '0);
    check_eq("rst_resp_err", W'(resp_err), '0);
    check_eq("rst_dp_opA", dp_opA, '0);
    check_eq("rst_dp_sub", W'(dp_sub), '0);

    // Contention from reset: grants alternate 0,1,0,1.
    rand_ops(0); rand_ops(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(2'b11, 0, g_seen);
      check_eq("order", W'(g_seen), W'(i % 2));
      rand_ops(int'(g_seen));
    end
    req_valid = 2'b00;

    // Directed add / sub cases.
    set_ops(0, 256'd50, 256'd60, 256'd97, 1'b0);
    do_op(2'b01, 0, g);
    set_ops(1, 256'd10, 256'd20, 256'd97, 1'b1);
    do_op(2'b10, 0, g);
    set_ops(1, 256'd0, 256'd1, ~256'd188, 1'b1);
    do_op(2'b10, 0, g);

    // Backpressure with requester 1 pending.
    set_ops(0, 256'd5, 256'd7, 256'd11, 1'b0);
    set_ops(1, 256'd3, 256'd9, 256'd11, 1'b1);
    do_op(2'b11, 3, g);
    check_eq("bp_owner", W'(g), 256'd0);
    req_valid = 2'b10;
    #1;
    check_eq("bp_next_grant", W'(req_ready), 256'd2);
    do_op(2'b10, 0, g);

    // Range error then a normal operation.
    set_ops(0, 256'd97, 256'd5, 256'd97, 1'b0);
    do_op(2'b01, 0, g);
    set_ops(0, 256'd96, 256'd5, 256'd97, 1'b0);
    do_op(2'b01, 0, g);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      req_valid = 2'b00;
      rand_ops(0); rand_ops(1);
      do_op(2'($urandom_range(1, 3)), $urandom_range(0, 2), g);
    end
    req_valid = 2'b00;

    // Reset during EXEC.
    set_ops(0, 256'd1, 256'd2, 256'd13, 1'b0);
    set_ops(1, 256'd4, 256'd2, 256'd13, 1'b1);
    req_valid = 2'b01;
    resp_ready = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    check_eq("mid_rst_valid", W'(resp_valid), '0);
    check_eq("mid_rst_data", resp_data, '0);
    check_eq("mid_rst_dp_opA", dp_opA, '0);
    check_eq("mid_rst_dp_opM", dp_opM, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_no_valid", W'(resp_valid), '0);
    end
    rst_n = 1'b1;
    mg = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid", W'(resp_valid), '0);
    do_op(2'b11, 0, g);
    check_eq("post_rst_tie", W'(g), 256'd0);
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
